// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate cache controller
// between the CPU load/store port and the cache bus unit.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cpu_req/we/uncached/addr/wdata  CPU access request (held until cpu_ready)
//   cpu_rdata/ready/err          CPU completion (one-cycle pulse)
//   cache_flush                  invalidate all lines (honoured in IDLE only)
//   read_line_req/read_req/write_through_req/pa/wt_data  bus unit requests
//   line_data/addr_count/line_write/cache_entry_refill/trans_rdy/bus_error
//                                bus unit responses
module cache_ctrl #(
    parameter int BUS_WIDTH = 8,
    parameter int BUS_ADDR  = 24,
    parameter int MAX_BURST = 128,
    parameter int NUM_LINES = 4,
    localparam int OFS_W = $clog2(MAX_BURST),
    localparam int IDX_W = $clog2(NUM_LINES),
    localparam int TAG_W = BUS_ADDR - IDX_W - OFS_W,
    localparam int ARR_W = IDX_W + OFS_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic                 cpu_uncached,
    input  logic [BUS_ADDR-1:0]  cpu_addr,
    input  logic [BUS_WIDTH-1:0] cpu_wdata,
    output logic [BUS_WIDTH-1:0] cpu_rdata,
    output logic                 cpu_ready,
    output logic                 cpu_err,
    input  logic                 cache_flush,
    output logic                 read_line_req,
    output logic                 read_req,
    output logic                 write_through_req,
    output logic [BUS_ADDR-1:0]  pa,
    output logic [BUS_WIDTH-1:0] wt_data,
    input  logic [BUS_WIDTH-1:0] line_data,
    input  logic [OFS_W-1:0]     addr_count,
    input  logic                 line_write,
    input  logic                 cache_entry_refill,
    input  logic                 trans_rdy,
    input  logic                 bus_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMP,
        S_REFILL,
        S_SRD,
        S_WT,
        S_RESP,
        S_ERR
    } state_e;

    state_e               state_q;
    logic [BUS_ADDR-1:0]  addr_q;
    logic [BUS_WIDTH-1:0] wdata_q;
    logic                 we_q;
    logic                 unc_q;
    logic                 wrote_q;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];
    logic [BUS_WIDTH-1:0] mem_q [NUM_LINES*MAX_BURST];

    logic                 rd_line_q;
    logic                 rd_q;
    logic                 wt_q;
    logic                 ready_q;
    logic                 err_q;
    logic [BUS_ADDR-1:0]  pa_q;
    logic [BUS_WIDTH-1:0] wt_data_q;
    logic [BUS_WIDTH-1:0] rdata_q;

    logic [TAG_W-1:0]     acc_tag;
    logic [IDX_W-1:0]     acc_idx;
    logic [OFS_W-1:0]     acc_ofs;
    logic                 hit;

    logic                 mem_we;
    logic [ARR_W-1:0]     mem_wa;
    logic [BUS_WIDTH-1:0] mem_wd;

    assign acc_tag = addr_q[BUS_ADDR-1 -: TAG_W];
    assign acc_idx = addr_q[OFS_W +: IDX_W];
    assign acc_ofs = addr_q[OFS_W-1:0];
    assign hit     = valid_q[acc_idx] && (tag_q[acc_idx] == acc_tag);

    assign cpu_rdata         = rdata_q;
    assign cpu_ready         = ready_q;
    assign cpu_err           = err_q;
    assign read_line_req     = rd_line_q;
    assign read_req          = rd_q;
    assign write_through_req = wt_q;
    assign pa                = pa_q;
    assign wt_data           = wt_data_q;

    // Single write port: refill beats and CMP store hits live in
    // different states, so they never contend.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = {acc_idx, acc_ofs};
        mem_wd = wdata_q;
        if (state_q == S_CMP && we_q && !unc_q && hit) begin
            mem_we = 1'b1;
        end else if (state_q == S_REFILL && line_write) begin
            mem_we = 1'b1;
            mem_wa = {acc_idx, addr_count};
            mem_wd = line_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            unc_q     <= 1'b0;
            wrote_q   <= 1'b0;
            valid_q   <= '0;
            rd_line_q <= 1'b0;
            rd_q      <= 1'b0;
            wt_q      <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            pa_q      <= '0;
            wt_data_q <= '0;
            rdata_q   <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    rdata_q <= '0;
                    if (cache_flush) begin
                        valid_q <= '0;
                    end else if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        we_q    <= cpu_we;
                        unc_q   <= cpu_uncached;
                        wrote_q <= 1'b0;
                        state_q <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (unc_q && !we_q) begin
                        rd_q    <= 1'b1;
                        pa_q    <= addr_q;
                        state_q <= S_SRD;
                    end else if (we_q) begin
                        wt_q      <= 1'b1;
                        pa_q      <= addr_q;
                        wt_data_q <= wdata_q;
                        // Remember a cached write so a failed
                        // write-through can drop the stale line.
                        wrote_q   <= !unc_q && hit;
                        state_q   <= S_WT;
                    end else if (hit) begin
                        rdata_q <= mem_q[{acc_idx, acc_ofs}];
                        ready_q <= 1'b1;
                        state_q <= S_RESP;
                    end else begin
                        rd_line_q <= 1'b1;
                        pa_q      <= {acc_tag, acc_idx, {OFS_W{1'b0}}};
                        state_q   <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (bus_error) begin
                        valid_q[acc_idx] <= 1'b0;
                        rd_line_q        <= 1'b0;
                        rdata_q          <= '0;
                        ready_q          <= 1'b1;
                        err_q            <= 1'b1;
                        state_q          <= S_ERR;
                    end else if (cache_entry_refill) begin
                        valid_q[acc_idx] <= 1'b1;
                        tag_q[acc_idx]   <= acc_tag;
                        rd_line_q        <= 1'b0;
                        state_q          <= S_CMP;
                    end
                end
                S_SRD: begin
                    if (bus_error) begin
                        rd_q    <= 1'b0;
                        rdata_q <= '0;
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else if (trans_rdy) begin
                        rd_q    <= 1'b0;
                        rdata_q <= line_data;
                        ready_q <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                S_WT: begin
                    if (bus_error) begin
                        if (wrote_q) begin
                            valid_q[acc_idx] <= 1'b0;
                        end
                        wt_q    <= 1'b0;
                        rdata_q <= '0;
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else if (trans_rdy) begin
                        wt_q    <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench for cache_ctrl with a small bus unit model.
// Refill beat data = beat + pa[16:9] - 1, so tag 1 lines read 0x00..0x7F.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_uncached;
    logic [23:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic        cache_flush;
    logic        read_line_req;
    logic        read_req;
    logic        write_through_req;
    logic [23:0] pa;
    logic [7:0]  wt_data;
    logic [7:0]  line_data;
    logic [6:0]  addr_count;
    logic        line_write;
    logic        cache_entry_refill;
    logic        trans_rdy;
    logic        bus_error;

    always #5 clk = ~clk;

    cache_ctrl #(
        .BUS_WIDTH(8),
        .BUS_ADDR (24),
        .MAX_BURST(128),
        .NUM_LINES(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_req           (cpu_req),
        .cpu_we            (cpu_we),
        .cpu_uncached      (cpu_uncached),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_rdata         (cpu_rdata),
        .cpu_ready         (cpu_ready),
        .cpu_err           (cpu_err),
        .cache_flush       (cache_flush),
        .read_line_req     (read_line_req),
        .read_req          (read_req),
        .write_through_req (write_through_req),
        .pa                (pa),
        .wt_data           (wt_data),
        .line_data         (line_data),
        .addr_count        (addr_count),
        .line_write        (line_write),
        .cache_entry_refill(cache_entry_refill),
        .trans_rdy         (trans_rdy),
        .bus_error         (bus_error)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          refills = 0;
    int          wts = 0;
    int          srds = 0;
    logic [23:0] rl_pa = '0;
    logic [23:0] wt_pa = '0;
    logic [7:0]  wt_d = '0;
    int          err_beat = -1;
    bit          wt_err = 1'b0;
    bit          flush_once = 1'b0;
    int          rl_beat = 0;
    int          wt_cnt = 0;
    int          sr_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus unit model: reacts one ns after each rising edge.
    initial begin
        line_write         = 1'b0;
        cache_entry_refill = 1'b0;
        trans_rdy          = 1'b0;
        bus_error          = 1'b0;
        line_data          = '0;
        addr_count         = '0;
        forever begin
            @(posedge clk);
            #1;
            line_write         = 1'b0;
            cache_entry_refill = 1'b0;
            trans_rdy          = 1'b0;
            bus_error          = 1'b0;
            if (flush_once) begin
                cache_flush = 1'b0;
                flush_once  = 1'b0;
            end
            if (read_line_req) begin
                if (rl_beat == 0) begin
                    refills++;
                    rl_pa = pa;
                end
                if (rl_beat < 128) begin
                    if (rl_beat == err_beat) begin
                        bus_error = 1'b1;
                    end else begin
                        line_write = 1'b1;
                        addr_count = 7'(rl_beat);
                        line_data  = 8'(rl_beat) + pa[16:9] - 8'd1;
                    end
                    rl_beat++;
                end else begin
                    cache_entry_refill = 1'b1;
                end
            end else begin
                rl_beat = 0;
            end
            if (write_through_req) begin
                if (wt_cnt == 0) begin
                    wts++;
                    wt_pa = pa;
                    wt_d  = wt_data;
                end
                if (wt_cnt == 2) begin
                    if (wt_err) bus_error = 1'b1;
                    else trans_rdy = 1'b1;
                end
                wt_cnt++;
            end else begin
                wt_cnt = 0;
            end
            if (read_req) begin
                if (sr_cnt == 0) srds++;
                if (sr_cnt == 2) begin
                    trans_rdy = 1'b1;
                    line_data = 8'hA5;
                end
                sr_cnt++;
            end else begin
                sr_cnt = 0;
            end
        end
    end

    // Called at a falling edge with the DUT idle; returns at a falling
    // edge with the DUT idle again. lat counts rising edges from accept.
    task automatic access(input logic we, input logic unc,
                          input logic [23:0] a, input logic [7:0] wd,
                          output logic [7:0] rd, output logic er,
                          output int lat);
        bit got;
        got = 1'b0;
        rd  = '0;
        er  = 1'b0;
        lat = 0;
        cpu_we       = we;
        cpu_uncached = unc;
        cpu_addr     = a;
        cpu_wdata    = wd;
        cpu_req      = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (cpu_ready) begin
                got = 1'b1;
                rd  = cpu_rdata;
                er  = cpu_err;
            end
        end
        cpu_req      = 1'b0;
        cpu_we       = 1'b0;
        cpu_uncached = 1'b0;
        check("ready_seen", 32'(got), 1);
        @(negedge clk);
        check("ready_pulse", 32'(cpu_ready), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       er;
        int         lat;
        int         r0;
        int         w0;
        int         s0;
        bit         got;

        rst          = 1'b1;
        cpu_req      = 1'b0;
        cpu_we       = 1'b0;
        cpu_uncached = 1'b0;
        cpu_addr     = '0;
        cpu_wdata    = '0;
        cache_flush  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(cpu_ready), 0);
        check("rst_err", 32'(cpu_err), 0);
        check("rst_rlreq", 32'(read_line_req), 0);
        check("rst_rdreq", 32'(read_req), 0);
        check("rst_wtreq", 32'(write_through_req), 0);
        check("rst_pa", 32'(pa), 0);
        check("rst_rdata", 32'(cpu_rdata), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_wtdata", 32'(wt_data), 0);

        // cold miss, line refill
        r0 = refills;
        access(1'b0, 1'b0, 24'h000234, 8'h00, rd, er, lat);
        check("miss_refills", 32'(refills - r0), 1);
        check("miss_pa", 32'(rl_pa), 32'h000200);
        check("miss_rdata", 32'(rd), 32'h34);
        check("miss_err", 32'(er), 0);
        check("miss_lat", 32'(lat), 132);

        // hit on the same line
        r0 = refills;
        access(1'b0, 1'b0, 24'h000210, 8'h00, rd, er, lat);
        check("hit_refills", 32'(refills - r0), 0);
        check("hit_rdata", 32'(rd), 32'h10);
        check("hit_lat", 32'(lat), 2);

        // store hit: write-through and array update
        w0 = wts;
        access(1'b1, 1'b0, 24'h000210, 8'h55, rd, er, lat);
        check("sth_wts", 32'(wts - w0), 1);
        check("sth_pa", 32'(wt_pa), 32'h000210);
        check("sth_data", 32'(wt_d), 32'h55);
        check("sth_err", 32'(er), 0);
        check("sth_lat", 32'(lat), 5);
        access(1'b0, 1'b0, 24'h000210, 8'h00, rd, er, lat);
        check("sth_reload", 32'(rd), 32'h55);
        check("sth_rel_lat", 32'(lat), 2);

        // store miss: write-through only, line untouched
        r0 = refills;
        w0 = wts;
        access(1'b1, 1'b0, 24'h800010, 8'h77, rd, er, lat);
        check("stm_wts", 32'(wts - w0), 1);
        check("stm_pa", 32'(wt_pa), 32'h800010);
        check("stm_data", 32'(wt_d), 32'h77);
        check("stm_refills", 32'(refills - r0), 0);
        access(1'b0, 1'b0, 24'h000210, 8'h00, rd, er, lat);
        check("stm_old_line", 32'(rd), 32'h55);
        r0 = refills;
        access(1'b0, 1'b0, 24'h800010, 8'h00, rd, er, lat);
        check("stm_ld_refill", 32'(refills - r0), 1);
        check("stm_ld_pa", 32'(rl_pa), 32'h800000);
        check("stm_ld_rdata", 32'(rd), 32'h0F);

        // conflict eviction on index 0
        r0 = refills;
        access(1'b0, 1'b0, 24'h000410, 8'h00, rd, er, lat);
        check("ev_refill", 32'(refills - r0), 1);
        check("ev_pa", 32'(rl_pa), 32'h000400);
        check("ev_rdata", 32'(rd), 32'h11);
        r0 = refills;
        access(1'b0, 1'b0, 24'h000234, 8'h00, rd, er, lat);
        check("ev_rl_again", 32'(refills - r0), 1);
        check("ev_rdata2", 32'(rd), 32'h34);

        // refill fault on beat 40
        err_beat = 40;
        r0 = refills;
        access(1'b0, 1'b0, 24'h000410, 8'h00, rd, er, lat);
        err_beat = -1;
        check("rfe_refill", 32'(refills - r0), 1);
        check("rfe_err", 32'(er), 1);
        check("rfe_rdata", 32'(rd), 0);
        r0 = refills;
        access(1'b0, 1'b0, 24'h000234, 8'h00, rd, er, lat);
        check("rfe_inval", 32'(refills - r0), 1);
        check("rfe_inval_rd", 32'(rd), 32'h34);
        r0 = refills;
        access(1'b0, 1'b0, 24'h000410, 8'h00, rd, er, lat);
        check("rfe_retry", 32'(refills - r0), 1);
        check("rfe_retry_rd", 32'(rd), 32'h11);
        check("rfe_retry_er", 32'(er), 0);

        // uncached load and store
        r0 = refills;
        s0 = srds;
        access(1'b0, 1'b1, 24'h123456, 8'h00, rd, er, lat);
        check("srd_count", 32'(srds - s0), 1);
        check("srd_rdata", 32'(rd), 32'hA5);
        check("srd_lat", 32'(lat), 5);
        check("srd_norefill", 32'(refills - r0), 0);
        w0 = wts;
        access(1'b1, 1'b1, 24'h000411, 8'h99, rd, er, lat);
        check("uwt_wts", 32'(wts - w0), 1);
        check("uwt_pa", 32'(wt_pa), 32'h000411);
        check("uwt_data", 32'(wt_d), 32'h99);
        access(1'b0, 1'b0, 24'h000411, 8'h00, rd, er, lat);
        check("uwt_no_write", 32'(rd), 32'h12);
        check("uwt_hit_lat", 32'(lat), 2);

        // write-through fault after a store hit drops the line
        wt_err = 1'b1;
        access(1'b1, 1'b0, 24'h000420, 8'h44, rd, er, lat);
        wt_err = 1'b0;
        check("wte_err", 32'(er), 1);
        check("wte_rdata", 32'(rd), 0);
        r0 = refills;
        access(1'b0, 1'b0, 24'h000420, 8'h00, rd, er, lat);
        check("wte_refill", 32'(refills - r0), 1);
        check("wte_rdata2", 32'(rd), 32'h21);

        // flush wins over a simultaneous hit request
        cache_flush = 1'b1;
        flush_once  = 1'b1;
        r0 = refills;
        access(1'b0, 1'b0, 24'h000430, 8'h00, rd, er, lat);
        check("fl_refill", 32'(refills - r0), 1);
        check("fl_rdata", 32'(rd), 32'h31);
        check("fl_lat", 32'(lat), 133);

        // reset in the middle of a refill
        cpu_we       = 1'b0;
        cpu_uncached = 1'b0;
        cpu_addr     = 24'h000000;
        cpu_req      = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (read_line_req) got = 1'b1;
        end
        check("mr_rl_seen", 32'(got), 1);
        repeat (10) @(negedge clk);
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        check("mr_rlreq", 32'(read_line_req), 0);
        check("mr_rdreq", 32'(read_req), 0);
        check("mr_wtreq", 32'(write_through_req), 0);
        check("mr_ready", 32'(cpu_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        r0 = refills;
        access(1'b0, 1'b0, 24'h000430, 8'h00, rd, er, lat);
        check("mr_inval", 32'(refills - r0), 1);
        check("mr_rdata", 32'(rd), 32'h31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
